// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream packet sink and its ready throttle.
package axis_pkg;

  localparam int ERR_W   = 4;
  localparam int POP_MAX = 128;

  typedef enum logic [1:0] {
    ERR_OVERLONG    = 2'd0,
    ERR_EMPTY_KEEP  = 2'd1,
    ERR_UNSTABLE    = 2'd2,
    ERR_SPARSE_KEEP = 2'd3
  } err_bit_t;

  typedef enum logic {
    THR_ON  = 1'b0,
    THR_OFF = 1'b1
  } thr_state_t;

  // Number of set bits in a keep vector zero-extended to POP_MAX bits.
  function automatic logic [7:0] popcount(input logic [POP_MAX-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_ready_throttle.sv
// Back-pressure generator: registered TREADY alternating between on and off windows.
module axis_ready_throttle
  import axis_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cfg_on_cycles,
  input  logic [7:0] cfg_off_cycles,
  output logic       tready,
  output logic       thr_off
);

  thr_state_t state, state_n;
  logic [7:0] rem, rem_n;
  logic       tready_n;
  logic       free_run;

  // A zero length for either window means the sink never throttles.
  assign free_run = (cfg_on_cycles == 8'd0) || (cfg_off_cycles == 8'd0);
  assign thr_off  = (state == THR_OFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= THR_ON;
      rem    <= 8'd0;
      tready <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      tready <= tready_n;
    end
  end

  // rem counts the cycles left in the current window after this one. Window
  // lengths are read only when a window is entered; in free-run every cycle
  // re-enters ON so a new configuration is picked up immediately.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    tready_n = tready;
    if (state == THR_ON) begin
      if (!tready || rem == 8'd0) begin
        // ON with TREADY low only occurs straight out of reset.
        if (tready && !free_run) begin
          state_n  = THR_OFF;
          rem_n    = cfg_off_cycles - 8'd1;
          tready_n = 1'b0;
        end else begin
          state_n  = THR_ON;
          rem_n    = free_run ? 8'd0 : cfg_on_cycles - 8'd1;
          tready_n = 1'b1;
        end
      end else begin
        rem_n = rem - 8'd1;
      end
    end else begin
      if (rem == 8'd0) begin
        state_n  = THR_ON;
        rem_n    = free_run ? 8'd0 : cfg_on_cycles - 8'd1;
        tready_n = 1'b1;
      end else begin
        rem_n = rem - 8'd1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_sink.sv
// Terminal AXI4-Stream consumer: throttled acceptance, per-packet beat/byte
// statistics and sticky protocol-error flags.
module axis_pkt_sink
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] TDATA,
  input  logic [KEEP_WIDTH-1:0] TKEEP,
  input  logic                  TVALID,
  output logic                  TREADY,
  input  logic                  TLAST,
  input  logic [7:0]            cfg_on_cycles,
  input  logic [7:0]            cfg_off_cycles,
  input  logic                  clr,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  last_beats,
  output logic [CNT_WIDTH-1:0]  last_bytes,
  output logic [ERR_W-1:0]      err_flags,
  output logic                  dbg_thr_off
);

  // Valid/ready: a beat transfers on a rising edge where TVALID and TREADY are
  // both high; once TVALID is raised the source must hold it and TDATA/TKEEP/
  // TLAST unchanged until that edge. Nothing else updates statistics.
  logic hs;
  assign hs = TVALID & TREADY;

  axis_ready_throttle u_throttle (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_on_cycles  (cfg_on_cycles),
    .cfg_off_cycles (cfg_off_cycles),
    .tready         (TREADY),
    .thr_off        (dbg_thr_off)
  );

  logic [CNT_WIDTH-1:0]  beat_cnt, byte_cnt;
  logic [CNT_WIDTH-1:0]  beat_next, byte_next, keep_bytes;
  logic [CNT_WIDTH:0]    byte_sum;
  logic [POP_MAX-1:0]    keep_ext;
  logic [ERR_W-1:0]      err_set;

  logic                  stall_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tlast_q;
  logic                  unstable;

  assign keep_ext   = {{(POP_MAX - KEEP_WIDTH){1'b0}}, TKEEP};
  assign keep_bytes = CNT_WIDTH'(popcount(keep_ext));

  // Running totals stick at all-ones rather than wrapping.
  always_comb begin
    beat_next = (&beat_cnt) ? beat_cnt : beat_cnt + CNT_WIDTH'(1);
    byte_sum  = {1'b0, byte_cnt} + {1'b0, keep_bytes};
    byte_next = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
  end

  // A stalled beat must be presented again unchanged on the following cycle.
  assign unstable = stall_q &&
                    (!TVALID || (TDATA != tdata_q) || (TKEEP != tkeep_q) || (TLAST != tlast_q));

  always_comb begin
    err_set               = '0;
    err_set[ERR_UNSTABLE] = unstable;
    if (hs) begin
      err_set[ERR_OVERLONG]    = 32'(beat_cnt) >= 32'(MAX_BEATS);
      err_set[ERR_EMPTY_KEEP]  = (TKEEP == '0);
      err_set[ERR_SPARSE_KEEP] = !TLAST && !(&TKEEP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
    end else begin
      stall_q <= TVALID & ~TREADY;
      tdata_q <= TDATA;
      tkeep_q <= TKEEP;
      tlast_q <= TLAST;
    end
  end

  // clr wins over a same-cycle beat: the beat is still accepted on the bus but
  // leaves no trace in the statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt   <= '0;
      byte_cnt   <= '0;
      pkt_count  <= '0;
      last_beats <= '0;
      last_bytes <= '0;
      err_flags  <= '0;
      pkt_done   <= 1'b0;
    end else if (clr) begin
      beat_cnt   <= '0;
      byte_cnt   <= '0;
      pkt_count  <= '0;
      last_beats <= '0;
      last_bytes <= '0;
      err_flags  <= '0;
      pkt_done   <= 1'b0;
    end else begin
      err_flags <= err_flags | err_set;
      pkt_done  <= hs & TLAST;
      if (hs) begin
        if (TLAST) begin
          last_beats <= beat_next;
          last_bytes <= byte_next;
          pkt_count  <= pkt_count + CNT_WIDTH'(1);
          beat_cnt   <= '0;
          byte_cnt   <= '0;
        end else begin
          beat_cnt <= beat_next;
          byte_cnt <= byte_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Randomized self-checking bench for axis_pkt_sink against a packet-level model.
module tb_axis_pkt_sink;

  localparam int DW   = 32;
  localparam int KW   = DW / 8;
  localparam int MAXB = 6;
  localparam int CW   = 8;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] TDATA;
  logic [KW-1:0] TKEEP;
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
  logic [7:0]    cfg_on_cycles;
  logic [7:0]    cfg_off_cycles;
  logic          clr;
  logic          pkt_done;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] last_beats;
  logic [CW-1:0] last_bytes;
  logic [3:0]    err_flags;
  logic          dbg_thr_off;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  axis_pkt_sink #(
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .TDATA          (TDATA),
    .TKEEP          (TKEEP),
    .TVALID         (TVALID),
    .TREADY         (TREADY),
    .TLAST          (TLAST),
    .cfg_on_cycles  (cfg_on_cycles),
    .cfg_off_cycles (cfg_off_cycles),
    .clr            (clr),
    .pkt_done       (pkt_done),
    .pkt_count      (pkt_count),
    .last_beats     (last_beats),
    .last_bytes     (last_bytes),
    .err_flags      (err_flags),
    .dbg_thr_off    (dbg_thr_off)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  int m_count, m_beats, m_bytes, m_last_beats, m_last_bytes;
  logic [3:0]      m_err;
  logic [2*CW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_beats = 0; m_bytes = 0;
    m_last_beats = 0; m_last_bytes = 0; m_err = '0;
    exp_q.delete();
  endtask

  // One accepted beat, described by the packet rules rather than by counters.
  task automatic model_beat(input logic [KW-1:0] k, input logic l, input logic c);
    int lb, ly;
    if (c) begin
      model_clear();
      return;
    end
    m_beats++;
    m_bytes += $countones(k);
    if (m_beats > MAXB) m_err[0] = 1'b1;
    if (k == '0) m_err[1] = 1'b1;
    if (!l && k != {KW{1'b1}}) m_err[3] = 1'b1;
    if (l) begin
      lb = (m_beats > SAT) ? SAT : m_beats;
      ly = (m_bytes > SAT) ? SAT : m_bytes;
      m_last_beats = lb;
      m_last_bytes = ly;
      m_count = (m_count + 1) % (SAT + 1);
      exp_q.push_back({CW'(lb), CW'(ly)});
      m_beats = 0;
      m_bytes = 0;
    end
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_pkt_count"}, 32'(pkt_count), m_count);
    check_eq({tag, "_last_beats"}, 32'(last_beats), m_last_beats);
    check_eq({tag, "_last_bytes"}, 32'(last_bytes), m_last_bytes);
    check_eq({tag, "_err_flags"}, 32'(err_flags), 32'(m_err));
  endtask

  // ---------------- driver tasks (entered and left just after a negedge) ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic c);
    int   waited = 0;
    bit   done = 0;
    logic [2*CW-1:0] e;
    TVALID = 1'b1; TDATA = d; TKEEP = k; TLAST = l; clr = c;
    while (!done && waited < 100) begin
      if (TREADY) begin
        @(posedge clk);
        model_beat(k, l, c);
        done = 1;
      end else begin
        @(posedge clk);
        waited++;
      end
      @(negedge clk);
    end
    clr = 1'b0;
    if (!done) begin
      check_eq("tready_wait", 32'(TREADY), 32'd1);
    end else if (l && !c) begin
      check_eq("pkt_done", 32'(pkt_done), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("done_beats", 32'(last_beats), 32'(e[2*CW-1:CW]));
        check_eq("done_bytes", 32'(last_bytes), 32'(e[CW-1:0]));
      end
    end else begin
      check_eq("pkt_done_low", 32'(pkt_done), 32'd0);
    end
  endtask

  task automatic send_pkt(input int n, input bit rnd_keep);
    logic [KW-1:0] k;
    for (int i = 0; i < n; i++) begin
      k = {KW{1'b1}};
      if (rnd_keep && $urandom_range(0, 3) == 0) k = KW'($urandom_range(0, (1 << KW) - 1));
      send_beat($urandom, k, i == n - 1, 1'b0);
    end
    TVALID = 1'b0;
    TLAST  = 1'b0;
    check_stats("pkt");
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check_stats("clr");
  endtask

  task automatic apply_reset();
    TVALID  = 1'b0;
    clr     = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_tready(input logic val);
    int n = 0;
    while (TREADY !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("tready_level", 32'(TREADY), 32'(val));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  sent;
    bit  hs;
    logic [2*CW-1:0] e;

    reset_n = 1'b0; TVALID = 1'b0; TDATA = '0; TKEEP = '0; TLAST = 1'b0;
    clr = 1'b0; cfg_on_cycles = 8'd0; cfg_off_cycles = 8'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_tready", 32'(TREADY), 32'd0);
    check_eq("rst_pkt_done", 32'(pkt_done), 32'd0);
    check_stats("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("first_tready", 32'(TREADY), 32'd1);

    // Always-ready: packets of 4, 1 and 8 full beats.
    send_pkt(4, 0);
    send_pkt(1, 0);
    send_pkt(8, 0);

    // Overlong packet, then clear.
    do_clr();
    send_pkt(MAXB + 1, 0);
    do_clr();

    // Partial keep on the last beat is legal; mid-packet it is sparse.
    send_beat($urandom, 4'hF, 1'b0, 1'b0);
    send_beat($urandom, 4'h3, 1'b1, 1'b0);
    check_stats("keep_last");
    send_beat($urandom, 4'h3, 1'b0, 1'b0);
    send_beat($urandom, 4'hF, 1'b1, 1'b0);
    TVALID = 1'b0;
    check_stats("keep_sparse");

    // Throttle pattern 2 on / 3 off from reset with TVALID held high.
    cfg_on_cycles = 8'd2; cfg_off_cycles = 8'd3;
    apply_reset();
    sent = 0;
    TVALID = 1'b1; TDATA = $urandom; TKEEP = 4'hF; TLAST = 1'b0;
    for (int i = 0; i < 25; i++) begin
      check_eq("thr_tready", 32'(TREADY), 32'((i % 5) < 2));
      check_eq("thr_state", 32'(dbg_thr_off), 32'((i % 5) >= 2));
      hs = TREADY && TVALID;
      @(posedge clk);
      if (hs) begin
        model_beat(4'hF, sent == 9, 1'b0);
        sent++;
      end
      @(negedge clk);
      if (sent < 10) begin
        if (hs) begin TDATA = $urandom; TLAST = (sent == 9); end
      end else begin
        TVALID = 1'b0; TLAST = 1'b0;
      end
    end
    check_eq("thr_sent", 32'(sent), 32'd10);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("thr_beats", 32'(last_beats), 32'(e[2*CW-1:CW]));
    end
    check_stats("thr");

    // Stall hazards under a 1 on / 4 off profile.
    cfg_on_cycles = 8'd1; cfg_off_cycles = 8'd4;
    do_clr();
    wait_tready(1'b1); wait_tready(1'b0);
    send_beat($urandom, 4'hF, 1'b1, 1'b0);
    TVALID = 1'b0; TLAST = 1'b0;
    check_stats("stall_ok");
    wait_tready(1'b1); wait_tready(1'b0);
    TVALID = 1'b1; TDATA = 32'h1234_5678; TKEEP = 4'hF; TLAST = 1'b1;
    @(negedge clk);
    TDATA = 32'h1234_5679;
    @(negedge clk);
    TVALID = 1'b0; TLAST = 1'b0;
    @(negedge clk);
    m_err[2] = 1'b1;
    check_stats("unstable_data");
    do_clr();
    wait_tready(1'b1); wait_tready(1'b0);
    TVALID = 1'b1; TDATA = $urandom; TKEEP = 4'hF; TLAST = 1'b1;
    @(negedge clk);
    TVALID = 1'b0; TLAST = 1'b0;
    @(negedge clk);
    m_err[2] = 1'b1;
    check_stats("unstable_drop");
    do_clr();
    send_beat($urandom, 4'h0, 1'b1, 1'b0);
    TVALID = 1'b0; TLAST = 1'b0;
    check_stats("empty_keep");

    // Reset in the middle of a packet.
    cfg_on_cycles = 8'd0; cfg_off_cycles = 8'd0;
    send_pkt(2, 0);
    send_beat($urandom, 4'hF, 1'b0, 1'b0);
    send_beat($urandom, 4'hF, 1'b0, 1'b0);
    TVALID = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("arst_tready", 32'(TREADY), 32'd0);
    check_eq("arst_pkt_count", 32'(pkt_count), 32'd0);
    check_eq("arst_last_beats", 32'(last_beats), 32'd0);
    check_eq("arst_last_bytes", 32'(last_bytes), 32'd0);
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
    send_pkt(3, 0);

    // clr on an accepted beat drops it and restarts the running packet.
    send_beat($urandom, 4'hF, 1'b0, 1'b0);
    send_beat($urandom, 4'hF, 1'b0, 1'b1);
    send_beat($urandom, 4'hF, 1'b1, 1'b0);
    TVALID = 1'b0; TLAST = 1'b0;
    check_stats("clr_beat");

    // Saturating accumulators and wrapping packet counter.
    send_pkt(70, 0);
    send_pkt(SAT + 5, 0);
    for (int p = 0; p < SAT + 5; p++) send_pkt(1, 0);

    // Random packets under changing back-pressure.
    do_clr();
    for (int p = 0; p < 40; p++) begin
      cfg_on_cycles  = 8'($urandom_range(0, 3));
      cfg_off_cycles = 8'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pkt($urandom_range(1, 9), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
